// File: rtl/serial_tx_frame.sv
// Framed parallel-to-serial transmitter: start bit, NUM_BITS data bits, optional
// even parity, stop bit, each held for a latched number of clocks.
module serial_tx_frame #(
  parameter int   NUM_BITS  = 8,
  parameter logic SHIFT_MSB = 1'b0,
  parameter logic PARITY_EN = 1'b0,
  parameter int   CNT_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [CNT_WIDTH-1:0] bit_period,
  input  logic [NUM_BITS-1:0]  tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 serial_out,
  output logic                 tx_busy,
  output logic                 frame_done
);

  localparam int BCW = $clog2(NUM_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  function automatic logic even_parity(input logic [NUM_BITS-1:0] d);
    return ^d;
  endfunction

  state_t               state_r, state_s;
  logic [NUM_BITS-1:0]  shift_r, shift_s;
  logic [CNT_WIDTH-1:0] timer_r, timer_s;
  logic [CNT_WIDTH-1:0] period_r, period_s;
  logic [BCW-1:0]       bit_cnt_r, bit_cnt_s;
  logic                 parity_r, parity_s;
  logic                 serial_out_r, serial_s;
  logic                 tx_ready_r, ready_s;
  logic                 tx_busy_r, busy_s;
  logic                 frame_done_r, done_s;
  logic                 bit_end_s;

  assign bit_end_s = (timer_r == (period_r - CNT_WIDTH'(1)));

  // Next-state logic: bit timing, shifting and frame sequencing
  always_comb begin
    state_s   = state_r;
    shift_s   = shift_r;
    timer_s   = timer_r;
    period_s  = period_r;
    bit_cnt_s = bit_cnt_r;
    parity_s  = parity_r;
    done_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (tx_valid) begin
          state_s   = ST_START;
          shift_s   = tx_data;
          period_s  = (bit_period == '0) ? CNT_WIDTH'(1) : bit_period;
          parity_s  = PARITY_EN ? even_parity(tx_data) : 1'b0;
          timer_s   = '0;
          bit_cnt_s = '0;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_START: begin
        if (bit_end_s) begin
          state_s = ST_DATA;
          timer_s = '0;
        end else begin
          timer_s = timer_r + CNT_WIDTH'(1);
        end
      end
      ST_DATA: begin
        if (bit_end_s) begin
          timer_s   = '0;
          bit_cnt_s = bit_cnt_r + BCW'(1);
          shift_s   = SHIFT_MSB ? {shift_r[NUM_BITS-2:0], 1'b0}
                                : {1'b0, shift_r[NUM_BITS-1:1]};
          if (bit_cnt_r == BCW'(NUM_BITS - 1)) begin
            state_s = PARITY_EN ? ST_PARITY : ST_STOP;
          end else begin
            state_s = ST_DATA;
          end
        end else begin
          timer_s = timer_r + CNT_WIDTH'(1);
        end
      end
      ST_PARITY: begin
        if (bit_end_s) begin
          state_s = ST_STOP;
          timer_s = '0;
        end else begin
          timer_s = timer_r + CNT_WIDTH'(1);
        end
      end
      ST_STOP: begin
        if (bit_end_s) begin
          state_s = ST_IDLE;
          timer_s = '0;
          done_s  = 1'b1;
        end else begin
          timer_s = timer_r + CNT_WIDTH'(1);
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so every output comes straight off a flop
  always_comb begin
    serial_s = 1'b1;
    ready_s  = 1'b0;
    busy_s   = 1'b1;
    case (state_s)
      ST_IDLE: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
      ST_START:  serial_s = 1'b0;
      ST_DATA:   serial_s = SHIFT_MSB ? shift_s[NUM_BITS-1] : shift_s[0];
      ST_PARITY: serial_s = parity_s;
      ST_STOP:   serial_s = 1'b1;
      default: begin
        ready_s = 1'b1;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state_r      <= ST_IDLE;
      shift_r      <= '0;
      timer_r      <= '0;
      period_r     <= '0;
      bit_cnt_r    <= '0;
      parity_r     <= 1'b0;
      serial_out_r <= 1'b1;
      tx_ready_r   <= 1'b1;
      tx_busy_r    <= 1'b0;
      frame_done_r <= 1'b0;
    end else begin
      state_r      <= state_s;
      shift_r      <= shift_s;
      timer_r      <= timer_s;
      period_r     <= period_s;
      bit_cnt_r    <= bit_cnt_s;
      parity_r     <= parity_s;
      serial_out_r <= serial_s;
      tx_ready_r   <= ready_s;
      tx_busy_r    <= busy_s;
      frame_done_r <= done_s;
    end
  end

  assign serial_out = serial_out_r;
  assign tx_ready   = tx_ready_r;
  assign tx_busy    = tx_busy_r;
  assign frame_done = frame_done_r;

endmodule

// File: tb/tb_serial_tx_frame.sv
// Randomized self-checking bench for serial_tx_frame: two instances (LSB-first plain,
// MSB-first with parity) compared against a bit-list frame model.
module tb_serial_tx_frame;

  logic        clk = 1'b0;
  logic        n_rst;
  logic [13:0] bit_period;
  logic [7:0]  tx_data;
  logic        valid0, valid1;
  logic        ready0, ready1, so0, so1, busy0, busy1, done0, done1;
  logic        sel;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  serial_tx_frame #(.NUM_BITS(8), .SHIFT_MSB(1'b0), .PARITY_EN(1'b0), .CNT_WIDTH(14)) dut0 (
    .clk(clk), .n_rst(n_rst), .bit_period(bit_period), .tx_data(tx_data),
    .tx_valid(valid0), .tx_ready(ready0), .serial_out(so0), .tx_busy(busy0),
    .frame_done(done0));

  serial_tx_frame #(.NUM_BITS(8), .SHIFT_MSB(1'b1), .PARITY_EN(1'b1), .CNT_WIDTH(14)) dut1 (
    .clk(clk), .n_rst(n_rst), .bit_period(bit_period), .tx_data(tx_data),
    .tx_valid(valid1), .tx_ready(ready1), .serial_out(so1), .tx_busy(busy1),
    .frame_done(done1));

  logic so_m, ready_m, busy_m, done_m;
  assign so_m    = sel ? so1 : so0;
  assign ready_m = sel ? ready1 : ready0;
  assign busy_m  = sel ? busy1 : busy0;
  assign done_m  = sel ? done1 : done0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference frame: list of line levels, one per serial bit
  task automatic build_bits(input bit msb, input bit par, input logic [7:0] d,
                            output bit bits[$]);
    bits = {};
    bits.push_back(1'b0);
    for (int k = 0; k < 8; k++) bits.push_back(msb ? d[7-k] : d[k]);
    if (par) bits.push_back(^d);
    bits.push_back(1'b1);
  endtask

  // Called just after a falling edge; returns just after the falling edge of the done cycle
  task automatic send_frame(input bit s, input logic [7:0] d, input logic [13:0] per,
                            input bit hold, input logic [7:0] nd, input logic [13:0] nper);
    bit          bits[$];
    int          p, f, waited;
    logic [7:0]  rx;
    sel = s;
    waited = 0;
    while (ready_m !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    check("ready_before_accept", ready_m, 1'b1);
    p = (per == 14'd0) ? 1 : int'(per);
    build_bits(s, s, d, bits);
    f = bits.size() * p;
    tx_data    = d;
    bit_period = per;
    valid0     = (s == 1'b0);
    valid1     = (s == 1'b1);
    @(posedge clk);
    @(negedge clk);
    rx = 8'h00;
    for (int c = 0; c < f; c++) begin
      check("serial_bit", so_m, bits[c / p]);
      check("busy_in_frame", busy_m, 1'b1);
      check("ready_in_frame", ready_m, 1'b0);
      check("done_in_frame", done_m, 1'b0);
      if (c % p == 0 && c / p >= 1 && c / p <= 8)
        rx = s ? {rx[6:0], so_m} : {so_m, rx[7:1]};
      if (c == 0) begin
        tx_data    = nd;
        bit_period = nper;
        valid0     = hold && (s == 1'b0);
        valid1     = hold && (s == 1'b1);
      end
      @(negedge clk);
    end
    check("rx_word", rx, d);
    check("frame_done_pulse", done_m, 1'b1);
    check("ready_after", ready_m, 1'b1);
    check("busy_after", busy_m, 1'b0);
    check("idle_line", so_m, 1'b1);
  endtask

  initial begin
    bit         pend;
    bit         s, hold;
    logic [7:0] d, nd;
    logic [13:0] per, nper;
    sel = 1'b0; n_rst = 1'b0; valid0 = 1'b1; valid1 = 1'b1;
    tx_data = 8'hFF; bit_period = 14'd3;
    // Reset held two edges with a valid word that must be discarded
    @(negedge clk);
    @(negedge clk);
    check("rst_serial", so0, 1'b1);
    check("rst_ready", ready0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_done", done0, 1'b0);
    check("rst_ready1", ready1, 1'b1);
    valid0 = 1'b0; valid1 = 1'b0; n_rst = 1'b1;
    @(negedge clk);
    check("no_accept_after_rst", busy0, 1'b0);
    check("no_accept_after_rst1", busy1, 1'b0);

    send_frame(1'b0, 8'hA5, 14'd4, 1'b0, 8'h00, 14'd4);
    @(negedge clk);
    check("done_one_cycle", done0, 1'b0);
    send_frame(1'b1, 8'h07, 14'd1, 1'b0, 8'h00, 14'd1);
    @(negedge clk);
    // Back-to-back with valid held: next accept lands on the single idle cycle
    send_frame(1'b0, 8'h3C, 14'd2, 1'b1, 8'hC3, 14'd2);
    send_frame(1'b0, 8'hC3, 14'd2, 1'b0, 8'h00, 14'd2);
    @(negedge clk);
    send_frame(1'b1, 8'h5A, 14'd0, 1'b0, 8'h00, 14'd0);
    @(negedge clk);
    // Period changed mid-frame: current frame keeps 3, next one runs at 9
    send_frame(1'b0, 8'h96, 14'd3, 1'b1, 8'h69, 14'd9);
    send_frame(1'b0, 8'h69, 14'd9, 1'b0, 8'h00, 14'd9);
    @(negedge clk);

    // Mid-frame reset during data bit 3
    sel = 1'b0; tx_data = 8'hF0; bit_period = 14'd4; valid0 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    valid0 = 1'b0;
    repeat (16) @(negedge clk);
    check("pre_rst_busy", busy0, 1'b1);
    n_rst = 1'b0;
    @(negedge clk);
    check("mrst_serial", so0, 1'b1);
    check("mrst_ready", ready0, 1'b1);
    check("mrst_busy", busy0, 1'b0);
    check("mrst_done", done0, 1'b0);
    n_rst = 1'b1;
    @(negedge clk);
    check("mrst_no_done", done0, 1'b0);
    send_frame(1'b0, 8'h81, 14'd2, 1'b0, 8'h00, 14'd2);

    // Randomized frames, some chained back-to-back
    pend = 1'b0; s = 1'b0; d = 8'h00; per = 14'd1;
    for (int i = 0; i < 24; i++) begin
      if (!pend) begin
        @(negedge clk);
        s   = 1'($urandom_range(0, 1));
        d   = 8'($urandom);
        per = 14'($urandom_range(0, 5));
      end
      hold = (i != 23) && ($urandom_range(0, 2) == 0);
      nd   = 8'($urandom);
      nper = 14'($urandom_range(0, 5));
      send_frame(s, d, per, hold, nd, nper);
      pend = hold;
      d    = nd;
      per  = nper;
    end
    valid0 = 1'b0; valid1 = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "watchdog");
  end

endmodule
